// File: rtl/lcd_msg_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_msg_arbiter
//   Shares the two 16-character LCD_module row buffers between a default text
//   source (live debug text) and NREQ event-message requesters. A fixed-priority
//   arbiter grants one message at a time and holds it on screen for HOLD_CYCLES
//   cycles. When nothing is shown, the default rows pass through with one cycle
//   of latency.
//
//   Handshake: a requester raises req[i] and keeps it high. The arbiter answers
//   with a one-cycle ack[i] pulse. The message text is captured on the same
//   edge that raises ack[i]. The requester drops req[i] on the edge that samples
//   ack[i]=1. While ack[j] is high, source j is not eligible, so a late drop
//   never causes a second grant. Dropping req before ack withdraws the request.
//
// Ports
//   clk_25MHz   in   system clock
//   reset_n     in   synchronous, active-low reset
//   dflt_row_a  in   default top row, char0 in [127:120]
//   dflt_row_b  in   default bottom row
//   req         in   level request per source, index 0 = highest priority
//   msg_row_a   in   packed top-row text, source i at [128*i +: 128]
//   msg_row_b   in   packed bottom-row text
//   cancel      in   abort the displayed message and return to default text
//   ack         out  one-cycle grant pulse per source
//   row_A       out  top row to LCD_module
//   row_B       out  bottom row to LCD_module
//   busy        out  1 while a message is displayed
//   cur_src     out  index of the displayed source (valid while busy)
//   dbg_state   out  FSM state (0 = IDLE, 1 = SHOW)
// ---------------------------------------------------------------------------
module lcd_msg_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int PREEMPT     = 1,
    parameter int MIN_SHOW    = 6_250_000,
    localparam int SRC_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk_25MHz,
    input  logic                  reset_n,
    input  logic [127:0]          dflt_row_a,
    input  logic [127:0]          dflt_row_b,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*128-1:0]   msg_row_a,
    input  logic [NREQ*128-1:0]   msg_row_b,
    input  logic                  cancel,
    output logic [NREQ-1:0]       ack,
    output logic [127:0]          row_A,
    output logic [127:0]          row_B,
    output logic                  busy,
    output logic [SRC_W-1:0]      cur_src,
    output logic                  dbg_state
);

    localparam int TIMER_W = $clog2(HOLD_CYCLES);
    localparam int SHOWN_W = $clog2(MIN_SHOW + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [SHOWN_W-1:0] SHOWN_MAX  = SHOWN_W'(MIN_SHOW);
    localparam logic [127:0]       QMARK_ROW  = {16{8'h3F}};

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;   // cycles left after the current one
    logic [SHOWN_W-1:0]   shown;   // cycles visible so far, saturates at MIN_SHOW

    logic [NREQ-1:0]      elig;
    logic                 any_elig;
    logic [SRC_W-1:0]     win_idx;
    logic [127:0]         win_row_a;
    logic [127:0]         win_row_b;
    logic                 preempt_ok;
    logic                 do_grant;

    assign dbg_state = state;

    // Lowest eligible index wins. A source whose ack is high this cycle is
    // excluded so that its still-high req is not granted a second time.
    always_comb begin
        elig      = req & ~ack;
        any_elig  = |elig;
        win_idx   = '0;
        win_row_a = '0;
        win_row_b = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx   = SRC_W'(i);
                win_row_a = msg_row_a[128*i +: 128];
                win_row_b = msg_row_b[128*i +: 128];
            end
        end
    end

    // Only a strictly higher-priority source may cut in, and only after the
    // current message has been visible for MIN_SHOW cycles.
    always_comb begin
        preempt_ok = (PREEMPT != 0) && (shown >= SHOWN_MAX) && any_elig && (win_idx < cur_src);
        do_grant   = 1'b0;
        if (!cancel) begin
            if (state == IDLE || timer == '0) begin
                do_grant = any_elig;
            end else begin
                do_grant = preempt_ok;
            end
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (!reset_n) begin
            state   <= IDLE;
            timer   <= '0;
            shown   <= '0;
            ack     <= '0;
            busy    <= 1'b0;
            cur_src <= '0;
            row_A   <= QMARK_ROW;
            row_B   <= QMARK_ROW;
        end else begin
            ack <= '0;
            if (cancel) begin
                state <= IDLE;
                busy  <= 1'b0;
                timer <= '0;
                shown <= '0;
                row_A <= dflt_row_a;
                row_B <= dflt_row_b;
            end else if (do_grant) begin
                state        <= SHOW;
                busy         <= 1'b1;
                cur_src      <= win_idx;
                ack[win_idx] <= 1'b1;
                timer        <= TIMER_LOAD;
                shown        <= SHOWN_W'(1);
                row_A        <= win_row_a;
                row_B        <= win_row_b;
            end else if (state == IDLE || timer == '0) begin
                // Idle pass-through, or expiry with nobody waiting.
                state <= IDLE;
                busy  <= 1'b0;
                row_A <= dflt_row_a;
                row_B <= dflt_row_b;
            end else begin
                timer <= timer - 1'b1;
                if (shown != SHOWN_MAX) begin
                    shown <= shown + 1'b1;
                end
            end
        end
    end

endmodule
